dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: latches one request, waits a fixed
// latency, then presents a held response until the initiator takes it.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          addr_err;
  logic [AW-1:0] word_idx;
  logic          commit;
  logic          mem_we;

  // Decode the latched request: error flag, word index and the completion edge.
  always_comb begin
    addr_err = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH_WORDS));
    word_idx = lat_addr[AW+1:2];
    commit   = (state == WAIT) && (cnt == '0);
    mem_we   = commit && lat_we && !addr_err;
  end

  // Request/response sequencing with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= CW'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= addr_err;
            // Load data is the word as it stands before this edge's store slot.
            rsp_rdata <= (lat_we || addr_err) ? 32'h0 : mem[word_idx];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane store commit on the WAIT->RESP edge; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) begin
          mem[word_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 main instance plus a LATENCY=1
// instance with rsp_ready tied high for back-to-back throughput.
module tb_dmem_responder;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH1 = 16;
  localparam int unsigned LAT1   = 1;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        err;
    int          due;
  } exp_t;

  logic clk;
  logic reset_n;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rmode    = 0;
  bit   gap_on   = 1'b0;
  int   last_acc [2];
  exp_t q0 [$];
  exp_t q1 [$];
  logic [31:0] mm [2][DEPTH];
  logic [31:0] kn [2][DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic fail(input string nm, input string msg);
    checks++;
    failures++;
    $display("FAIL %s: %s (cycle %0d)", nm, msg, cyc);
  endtask

  function automatic logic addr_bad(input logic [31:0] a, input int unsigned depth);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(depth));
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Issue one request; on acceptance compute the expected response and queue it.
  task automatic send(input int sel, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    int n, idx, acc;
    logic rdy;
    logic [31:0] mk;
    int unsigned dep;
    dep = (sel != 0) ? DEPTH1 : DEPTH;
    if (sel != 0) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
    end else begin
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 300) begin
      @(negedge clk);
      n++;
      rdy = (sel != 0) ? b_req_ready : req_ready;
    end
    if (!rdy) begin
      fail($sformatf("accept_timeout%0d", sel), "req_ready never rose");
      if (sel != 0) b_req_valid = 1'b0; else req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (gap_on && last_acc[sel] >= 0)
      chk($sformatf("accept_gap%0d", sel), 32'(acc - last_acc[sel]),
          32'(((sel != 0) ? LAT1 : LAT) + 2));
    last_acc[sel] = acc;
    e.due   = acc + ((sel != 0) ? int'(LAT1) : int'(LAT));
    e.err   = 1'b0;
    e.rdata = '0;
    e.mask  = '1;
    if (addr_bad(addr, dep)) begin
      e.err = 1'b1;
    end else begin
      idx = int'(addr >> 2);
      if (we) begin
        mk = lane_mask(be);
        mm[sel][idx] = (mm[sel][idx] & ~mk) | (wdata & mk);
        kn[sel][idx] = kn[sel][idx] | mk;
      end else begin
        e.rdata = mm[sel][idx];
        e.mask  = kn[sel][idx];
      end
    end
    if (sel != 0) q1.push_back(e); else q0.push_back(e);
    @(posedge clk);
    #1;
    if (sel != 0) begin
      b_req_valid = 1'b0; b_req_addr = $urandom; b_req_wdata = $urandom; b_req_we = 1'($urandom);
    end else begin
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
      req_be = 4'($urandom);
    end
  endtask

  // Wait (bounded) until the selected instance is idle with nothing outstanding.
  task automatic wait_idle(input int sel);
    int n;
    bit ok;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 300) begin
      @(negedge clk);
      n++;
      if (sel != 0) ok = (q1.size() == 0) && !b_rsp_valid && b_req_ready;
      else          ok = (q0.size() == 0) && !rsp_valid && req_ready;
    end
    if (!ok) fail($sformatf("idle_timeout%0d", sel), "responder did not return to idle");
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop the expected entry when a response appears, check it every RESP cycle.
  task automatic monitor(input int sel);
    exp_t cur;
    bit busy, after, have;
    logic v, rr, qr, er;
    logic [31:0] d;
    busy = 1'b0; after = 1'b0; have = 1'b0;
    cur = '{rdata: '0, mask: '0, err: 1'b0, due: 0};
    forever begin
      @(negedge clk);
      if (sel != 0) begin
        v = b_rsp_valid; rr = 1'b1; qr = b_req_ready; er = b_rsp_err; d = b_rsp_rdata;
      end else begin
        v = rsp_valid; rr = rsp_ready; qr = req_ready; er = rsp_err; d = rsp_rdata;
      end
      if (!reset_n) begin
        busy = 1'b0;
        after = 1'b0;
      end else begin
        if (after) begin
          chk($sformatf("rsp_valid_after_hs%0d", sel), 32'(v), 32'(0));
          chk($sformatf("req_ready_after_hs%0d", sel), 32'(qr), 32'(1));
          after = 1'b0;
        end else if (busy && !v) begin
          fail($sformatf("rsp_valid_early_drop%0d", sel), "rsp_valid fell without handshake");
          busy = 1'b0;
        end
        if (v) begin
          if (!busy) begin
            busy = 1'b1;
            have = 1'b0;
            if (sel != 0 && q1.size() > 0) begin cur = q1.pop_front(); have = 1'b1; end
            if (sel == 0 && q0.size() > 0) begin cur = q0.pop_front(); have = 1'b1; end
            if (have) chk($sformatf("rsp_latency%0d", sel), 32'(cyc), 32'(cur.due));
            else fail($sformatf("rsp_unexpected%0d", sel), "response with empty scoreboard");
          end
          if (have) begin
            chk($sformatf("rsp_rdata%0d", sel), d & cur.mask, cur.rdata & cur.mask);
            chk($sformatf("rsp_err%0d", sel), 32'(er), 32'(cur.err));
          end
          chk($sformatf("req_ready_busy%0d", sel), 32'(qr), 32'(0));
          if (rr) begin
            busy = 1'b0;
            after = 1'b1;
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // rsp_ready driver: 0 = always ready, 1 = random, 2 = stall five cycles per response.
  initial begin
    int stall_c;
    stall_c = 0;
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: rsp_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (rsp_valid && stall_c < 5) begin
            rsp_ready = 1'b0;
            stall_c++;
          end else begin
            rsp_ready = 1'b1;
            if (!rsp_valid) stall_c = 0;
          end
        end
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(1));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'(0));
  endtask

  initial begin
    int n;
    logic [31:0] a;
    for (int s = 0; s < 2; s++) begin
      last_acc[s] = -1;
      for (int w = 0; w < int'(DEPTH); w++) begin
        mm[s][w] = '0;
        kn[s][w] = '0;
      end
    end
    reset_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_b_req_ready", 32'(b_req_ready), 32'(1));
    chk("reset_b_rsp_valid", 32'(b_rsp_valid), 32'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Full-word store then load back, then partial-lane overwrite.
    send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0);
    send(0, 1'b1, 32'h10, 32'h00001234, 4'b0011);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0);
    send(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    // Misaligned and out-of-range loads, then the word must be unchanged.
    send(0, 1'b0, 32'h13, 32'h0, 4'hF);
    send(0, 1'b0, 32'h400, 32'h0, 4'hF);
    send(0, 1'b1, 32'h401, 32'h11111111, 4'hF);
    send(0, 1'b0, 32'h10, 32'h0, 4'hF);
    wait_idle(0);

    // Response held under backpressure.
    rmode = 2;
    send(0, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_idle(0);
    rmode = 0;

    // Throughput with rsp_ready held high.
    last_acc[0] = -1;
    gap_on = 1'b1;
    for (int i = 0; i < 4; i++) send(0, 1'b0, 32'h10, 32'h0, 4'h0);
    gap_on = 1'b0;
    wait_idle(0);

    // Reset while a store is in WAIT discards the store.
    send(0, 1'b1, 32'h20, 32'h0, 4'hF);
    wait_idle(0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555; req_be = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 300);
    if (!req_ready) fail("reset_case_accept", "req_ready never rose");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    chk_reset_outputs("mid_reset_hold");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send(0, 1'b0, 32'h20, 32'h0, 4'h0);
    wait_idle(0);

    // Randomized traffic with random backpressure.
    rmode = 1;
    for (int i = 0; i < 120; i++) begin
      n = int'($urandom_range(0, 9));
      if (n == 0)      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else if (n == 1) a = 32'((DEPTH + $urandom_range(0, 4000)) * 4);
      else             a = 32'($urandom_range(0, 31) * 4);
      send(0, 1'($urandom), a, $urandom, 4'($urandom));
    end
    wait_idle(0);
    rmode = 0;

    // LATENCY=1 instance: back-to-back stores and loads, rsp_ready tied high.
    last_acc[1] = -1;
    gap_on = 1'b1;
    for (int i = 0; i < 4; i++) send(1, 1'b1, 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 4; i++) send(1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
    send(1, 1'b0, 32'(DEPTH1 * 4), 32'h0, 4'h0);
    gap_on = 1'b0;
    wait_idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
